// File: rtl/fw_pe_multi.sv
// fw_pe_multi: Floyd-Warshall min-plus PE with LANES-wide beats, row/pivot local stores and a 3-stage pipeline.
// Optional feature macro FW_PE_SAT_EN: saturating add where all-ones is infinity; otherwise the add wraps.
module fw_pe_multi #(
    parameter int WIDTH   = 16,
    parameter int LANES   = 4,
    parameter int DEPTH   = 16,
    parameter int ID      = 0,
    parameter int ID_W    = 4,
    parameter int SEL_W   = $clog2(LANES),
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int INSTR_W = 4 + ID_W + SEL_W + ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   in,
    input  logic [INSTR_W-1:0]       instr_in,
    output logic [LANES*WIDTH-1:0]   out,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       instr_out
);
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_LOAD0   = 3'd1,
        OP_LOAD1   = 3'd2,
        OP_COMPUTE = 3'd3,
        OP_FORWARD = 3'd4,
        OP_CLEAR   = 3'd5
    } op_t;

    logic [2:0]        op_raw;
    logic [ID_W-1:0]   pe_id;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr1;
    logic              inhibit;
    logic              hit;
    op_t               op;

    assign {inhibit, addr1, sel, pe_id, op_raw} = instr_in;
    assign hit = pe_id == ID_W'(ID);

    // Decode: addressed ops aimed at another PE pass through as FORWARD, codes 6-7 are IDLE
    always_comb begin
        op = OP_IDLE;
        case (op_raw)
            3'd1: op = hit ? OP_LOAD0 : OP_FORWARD;
            3'd2: op = hit ? OP_LOAD1 : OP_FORWARD;
            3'd3: op = hit ? OP_COMPUTE : OP_FORWARD;
            3'd4: op = OP_FORWARD;
            3'd5: op = hit ? OP_CLEAR : OP_FORWARD;
            default: op = OP_IDLE;
        endcase
    end

    logic [LANES*WIDTH-1:0] ls0 [DEPTH];
    logic [LANES*WIDTH-1:0] ls1 [DEPTH];
    logic [ADDR_W-1:0]      wp0, wp1, rp0;
    logic [LANES*WIDTH-1:0] rd0, rd1;

    // Local-store writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (op == OP_LOAD0) ls0[wp0] <= in;
        if (op == OP_LOAD1) ls1[wp1] <= in;
    end

    // Stage 1 synchronous reads; a colliding write is seen only next cycle (read-first)
    always_ff @(posedge clk) begin
        rd0 <= ls0[rp0];
        rd1 <= ls1[addr1];
    end

    // Store pointers wrap naturally at DEPTH; CLEAR rewinds them without touching contents
    always_ff @(posedge clk) begin
        if (reset || op == OP_CLEAR) begin
            wp0 <= '0;
            wp1 <= '0;
            rp0 <= '0;
        end else begin
            if (op == OP_LOAD0) wp0 <= wp0 + 1'b1;
            if (op == OP_LOAD1) wp1 <= wp1 + 1'b1;
            if (op == OP_COMPUTE) rp0 <= rp0 + 1'b1;
        end
    end

    op_t                    s1_op, s2_op;
    logic                   s1_inh, s2_inh;
    logic [SEL_W-1:0]       s1_sel;
    logic [LANES*WIDTH-1:0] s1_in, s2_in, d0;
    logic [WIDTH-1:0]       d1;
    logic [INSTR_W-1:0]     s1_instr, s2_instr;

    // Pipeline stages 1-2: control is flushed by reset, data simply follows
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_op    <= OP_IDLE;
            s2_op    <= OP_IDLE;
            s1_instr <= '0;
            s2_instr <= '0;
        end else begin
            s1_op    <= op;
            s2_op    <= s1_op;
            s1_instr <= instr_in;
            s2_instr <= s1_instr;
        end
        s1_inh <= inhibit;
        s1_sel <= sel;
        s1_in  <= in;
        s2_inh <= s1_inh;
        s2_in  <= s1_in;
        d0     <= rd0;
        d1     <= rd1[s1_sel*WIDTH +: WIDTH];
    end

    function automatic logic [WIDTH-1:0] add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef FW_PE_SAT_EN
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s[WIDTH] || &a || &b) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Ties keep the incoming word, which is value-identical anyway
    function automatic logic [WIDTH-1:0] min_plus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        s = add(a, b);
        return (x <= s) ? x : s;
    endfunction

    logic [LANES*WIDTH-1:0] res;

    // Stage 3 datapath: per-lane min(in, d0 + broadcast d1)
    always_comb begin
        res = '0;
        for (int i = 0; i < LANES; i++)
            res[i*WIDTH +: WIDTH] = min_plus(s2_in[i*WIDTH +: WIDTH], d0[i*WIDTH +: WIDTH], d1);
    end

    // Output register: result, pass-through beat, or zero when nothing is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            instr_out <= '0;
        end else begin
            instr_out <= s2_instr;
            out_valid <= s2_op == OP_COMPUTE || s2_op == OP_FORWARD;
            out       <= (s2_op == OP_COMPUTE && !s2_inh) ? res :
                         (s2_op == OP_COMPUTE || s2_op == OP_FORWARD) ? s2_in : '0;
        end
    end
endmodule

// File: tb/tb_fw_pe_multi.sv
// tb_fw_pe_multi: scoreboard bench for fw_pe_multi (WIDTH=16, LANES=4, DEPTH=4, ID=2).
module tb_fw_pe_multi;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in;
    logic [11:0] instr_in;
    logic [63:0] out;
    logic        out_valid;
    logic [11:0] instr_out;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [63:0] data;
        logic [11:0] instr;
    } exp_t;
    exp_t sb[$];

    fw_pe_multi #(.WIDTH(16), .LANES(4), .DEPTH(4), .ID(2), .ID_W(4)) dut (
        .clk(clk), .reset(reset), .in(in), .instr_in(instr_in),
        .out(out), .out_valid(out_valid), .instr_out(instr_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mk(input int inh, input int a1, input int sel, input int id, input int op);
        return {1'(inh), 2'(a1), 2'(sel), 4'(id), 3'(op)};
    endfunction

    function automatic logic [63:0] beat(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, a, e);
        end
    endtask

    task automatic issue(input logic [11:0] ins, input logic [63:0] d, input bit exp, input logic [63:0] e);
        instr_in = ins;
        in = d;
        if (exp) sb.push_back('{cyc + 3, e, ins});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented beat must match the oldest expectation, at the expected cycle
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat out=%h instr_out=%h cycle=%0d", out, instr_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out !== e.data || instr_out !== e.instr || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL beat got out=%h instr_out=%h cycle=%0d expected out=%h instr_out=%h cycle=%0d",
                             out, instr_out, cyc, e.data, e.instr, e.cyc);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        in = '0;
        instr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out, 64'h0);
        chk("reset_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_instr_out", {52'h0, instr_out}, 64'h0);
        reset = 1'b0;
        // rows k*{1,2,3,4}; pivot blocks lane i = 16*(j+1)+i
        for (int k = 1; k <= 4; k++) issue(mk(0, 0, 0, 2, 1), beat(k, 2*k, 3*k, 4*k), 0, '0);
        for (int j = 0; j < 4; j++)
            issue(mk(0, 0, 0, 2, 2), beat(16*(j+1), 16*(j+1)+1, 16*(j+1)+2, 16*(j+1)+3), 0, '0);
        issue(mk(0, 1, 2, 2, 3), beat(100, 100, 100, 100), 1, beat(35, 36, 37, 38));
        issue(mk(0, 1, 2, 3, 3), beat('h1111, 'h2222, 'h3333, 'h4444), 1, beat('h1111, 'h2222, 'h3333, 'h4444));
        issue(mk(1, 0, 0, 2, 3), beat(5, 6, 7, 8), 1, beat(5, 6, 7, 8));
        issue(mk(0, 0, 0, 2, 3), beat(19, 100, 20, 0), 1, beat(19, 22, 20, 0));
        issue(mk(0, 3, 3, 2, 3), beat(70, 200, 79, 'hFFFF), 1, beat(70, 75, 79, 83));
        issue(mk(0, 3, 1, 9, 4), beat(1, 2, 3, 4), 1, beat(1, 2, 3, 4));
        issue(mk(0, 0, 0, 2, 0), beat(9, 9, 9, 9), 0, '0);
        issue(mk(0, 0, 0, 2, 6), beat(9, 9, 9, 9), 0, '0);
        issue(mk(0, 0, 0, 0, 7), beat(9, 9, 9, 9), 0, '0);
        issue(mk(0, 0, 0, 0, 2), beat(9, 9, 9, 9), 1, beat(9, 9, 9, 9));
        issue(mk(0, 0, 0, 15, 5), beat('hC, 'hC, 'hC, 'hC), 1, beat('hC, 'hC, 'hC, 'hC));
        // infinity arithmetic
        issue(mk(0, 0, 0, 2, 5), '0, 0, '0);
        issue(mk(0, 0, 0, 1, 1), beat('hBAD, 'hBAD, 'hBAD, 'hBAD), 1, beat('hBAD, 'hBAD, 'hBAD, 'hBAD));
        issue(mk(0, 0, 0, 2, 1), beat('hFFFF, 'hFFF0, 1, 'h8000), 0, '0);
        issue(mk(0, 0, 0, 2, 1), beat('hFFFF, 'hFFF0, 1, 'h8000), 0, '0);
        issue(mk(0, 0, 0, 2, 2), beat(5, 'h20, 0, 0), 0, '0);
`ifdef FW_PE_SAT_EN
        issue(mk(0, 0, 0, 2, 3), beat(7, 'hFFFF, 7, 'hFFFF), 1, beat(7, 'hFFF5, 6, 'h8005));
        issue(mk(0, 0, 1, 2, 3), beat('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), 1, beat('hFFFF, 'hFFFF, 'h21, 'h8020));
`else
        issue(mk(0, 0, 0, 2, 3), beat(7, 'hFFFF, 7, 'hFFFF), 1, beat(4, 'hFFF5, 6, 'h8005));
        issue(mk(0, 0, 1, 2, 3), beat('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), 1, beat('h1F, 'h10, 'h21, 'h8020));
`endif
        // wrap of the write pointer, then CLEAR followed by a LOAD0 hitting entry 0
        issue(mk(0, 0, 0, 2, 5), '0, 0, '0);
        for (int k = 0; k <= 4; k++) issue(mk(0, 0, 0, 2, 1), beat(k+1, 'h100+k, 'h200+k, 'h300+k), 0, '0);
        issue(mk(0, 0, 0, 2, 5), '0, 0, '0);
        issue(mk(0, 0, 2, 2, 3), beat('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), 1, beat(5, 'h104, 'h204, 'h304));
        issue(mk(0, 0, 0, 2, 5), '0, 0, '0);
        issue(mk(0, 0, 0, 2, 1), beat('h77, 'h88, 'h99, 'hAA), 0, '0);
        issue(mk(0, 0, 2, 2, 3), beat('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), 1, beat('h77, 'h88, 'h99, 'hAA));
        repeat (4) issue(mk(0, 0, 0, 2, 0), '0, 0, '0);
        // reset with computes in flight: nothing may emerge afterwards
        issue(mk(0, 0, 0, 2, 3), beat(1, 1, 1, 1), 0, '0);
        issue(mk(0, 0, 0, 2, 3), beat(2, 2, 2, 2), 0, '0);
        reset = 1'b1;
        issue(mk(0, 0, 0, 2, 3), beat(3, 3, 3, 3), 0, '0);
        chk("flush_out", out, 64'h0);
        chk("flush_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_instr_out", {52'h0, instr_out}, 64'h0);
        reset = 1'b0;
        repeat (4) issue(mk(0, 0, 0, 2, 0), '0, 0, '0);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
